guess_game_ctrl: RTL and testbench

//  Parametrised multi-round controller for the number-guessing game.
//  - Sequences rounds: accepts guesses, counts remaining tries, keeps score and drives the timer and display selects.
//  - Sits between the debounced button, the guess checker, the countdown timer and the LED/seg display muxes.
//  - Adds to the single-round controller: edge-detected button, try limit, multi-round play, score and game-over.

---
 rtl/guess_game_ctrl.sv | 132 +++++++++++++
 tb/tb_guess_game_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Multi-round number-guessing game controller: edge-detected button, per-round
// try limit, saturating score, round sequencing and Moore-decoded display/timer selects.
module guess_game_ctrl #(
  parameter int unsigned         RES_W        = 6,
  parameter logic [RES_W-1:0]    CORRECT_CODE = 6'b100000,
  parameter int unsigned         MAX_TRIES    = 5,
  parameter int unsigned         N_ROUNDS     = 3,
  parameter int unsigned         SCORE_W      = 4,
  localparam int unsigned        TRY_W        = $clog2(MAX_TRIES + 1),
  localparam int unsigned        RND_W        = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  input  logic [RES_W-1:0]   check_result,
  input  logic               timer_finish,
  output logic               check_start,
  output logic               timer_en,
  output logic               timer_set,
  output logic [2:0]         led_sel,
  output logic [2:0]         seg_sel,
  output logic [TRY_W-1:0]   tries_left,
  output logic [SCORE_W-1:0] score,
  output logic [RND_W-1:0]   round_idx,
  output logic               game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_WAIT  = 3'b001,
    S_HINT  = 3'b010,
    S_RIGHT = 3'b011,
    S_WRONG = 3'b100,
    S_OVER  = 3'b101
  } state_t;

  localparam logic [TRY_W-1:0] TRIES_FULL = TRY_W'(MAX_TRIES);
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(N_ROUNDS - 1);

  state_t             r_state;
  logic               r_btn_q;
  logic [TRY_W-1:0]   r_tries;
  logic [SCORE_W-1:0] r_score;
  logic [RND_W-1:0]   r_round;
  logic               r_check_start;

  logic w_btn_rise;
  logic w_correct;

  assign w_btn_rise = btn & ~r_btn_q;
  assign w_correct  = (check_result == CORRECT_CODE);

  // State, counters and the accept pulse; reset dominates every event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_btn_q       <= 1'b1;
      r_tries       <= TRIES_FULL;
      r_score       <= '0;
      r_round       <= '0;
      r_check_start <= 1'b0;
    end else begin
      r_btn_q       <= btn;
      r_check_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_btn_rise) begin
            r_state <= S_WAIT;
            r_tries <= TRIES_FULL;
          end
        end
        S_WAIT: begin
          // A timeout is not a guess: no accept pulse, tries untouched.
          if (timer_finish) begin
            r_state <= S_WRONG;
          end else if (w_btn_rise) begin
            r_check_start <= 1'b1;
            if (w_correct) begin
              r_state <= S_RIGHT;
              if (r_score != '1) r_score <= r_score + SCORE_W'(1);
            end else if (r_tries == TRY_W'(1)) begin
              r_state <= S_WRONG;
              r_tries <= '0;
            end else begin
              r_state <= S_HINT;
              r_tries <= r_tries - TRY_W'(1);
            end
          end
        end
        S_HINT: begin
          if (timer_finish) begin
            r_state <= S_WRONG;
          end else if (w_btn_rise) begin
            r_state <= S_WAIT;
          end
        end
        S_RIGHT, S_WRONG: begin
          if (w_btn_rise) begin
            if (r_round == LAST_ROUND) begin
              r_state <= S_OVER;
            end else begin
              r_state <= S_WAIT;
              r_round <= r_round + RND_W'(1);
              r_tries <= TRIES_FULL;
            end
          end
        end
        S_OVER: begin
          if (w_btn_rise) begin
            r_state <= S_IDLE;
            r_score <= '0;
            r_round <= '0;
            r_tries <= TRIES_FULL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the registered state.
  assign led_sel     = r_state;
  assign seg_sel     = r_state;
  assign timer_en    = (r_state == S_WAIT) || (r_state == S_HINT);
  assign timer_set   = ~timer_en;
  assign game_over   = (r_state == S_OVER);
  assign check_start = r_check_start;
  assign tries_left  = r_tries;
  assign score       = r_score;
  assign round_idx   = r_round;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed, table-driven bench for guess_game_ctrl with default parameters.
module tb_guess_game_ctrl;

  logic       clk;
  logic       rst;
  logic       btn;
  logic [5:0] check_result;
  logic       timer_finish;
  logic       check_start;
  logic       timer_en;
  logic       timer_set;
  logic [2:0] led_sel;
  logic [2:0] seg_sel;
  logic [2:0] tries_left;
  logic [3:0] score;
  logic [1:0] round_idx;
  logic       game_over;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [5:0] CW = 6'b100000;
  localparam logic [5:0] CX = 6'b000001;

  guess_game_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .check_result (check_result),
    .timer_finish (timer_finish),
    .check_start  (check_start),
    .timer_en     (timer_en),
    .timer_set    (timer_set),
    .led_sel      (led_sel),
    .seg_sel      (seg_sel),
    .tries_left   (tries_left),
    .score        (score),
    .round_idx    (round_idx),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       r;
    logic       b;
    logic [5:0] c;
    logic       t;
    logic [2:0] sel;
    logic       cs;
    logic [2:0] tr;
    logic [3:0] sc;
    logic [1:0] rn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic b, input logic [5:0] c,
                              input logic t, input logic [2:0] sel, input logic cs,
                              input logic [2:0] tr, input logic [3:0] sc,
                              input logic [1:0] rn);
    vec_t v;
    v.r = r; v.b = b; v.c = c; v.t = t;
    v.sel = sel; v.cs = cs; v.tr = tr; v.sc = sc; v.rn = rn;
    return v;
  endfunction

  task automatic cmp(input string tag, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic b, input logic [5:0] c, input logic t);
    rst = r; btn = b; check_result = c; timer_finish = t;
    @(posedge clk);
    #1;
  endtask

  // Timer enables follow the state table: counting only in WAIT and HINT.
  task automatic expect_out(input string tag, input logic [2:0] sel, input logic cs,
                            input logic [2:0] tr, input logic [3:0] sc,
                            input logic [1:0] rn);
    logic exp_en;
    exp_en = (sel == 3'd1) || (sel == 3'd2);
    cmp(tag, "led_sel",     32'(led_sel),     32'(sel));
    cmp(tag, "seg_sel",     32'(seg_sel),     32'(sel));
    cmp(tag, "check_start", 32'(check_start), 32'(cs));
    cmp(tag, "tries_left",  32'(tries_left),  32'(tr));
    cmp(tag, "score",       32'(score),       32'(sc));
    cmp(tag, "round_idx",   32'(round_idx),   32'(rn));
    cmp(tag, "game_over",   32'(game_over),   32'(sel == 3'd5));
    cmp(tag, "timer_en",    32'(timer_en),    32'(exp_en));
    cmp(tag, "timer_set",   32'(timer_set),   32'(!exp_en));
  endtask

  // Release then press; the release cycle never yields an accept pulse.
  task automatic press(input string tag, input logic [5:0] c, input logic [2:0] sel,
                       input logic cs, input logic [2:0] tr, input logic [3:0] sc,
                       input logic [1:0] rn);
    cyc(1'b1, 1'b0, c, 1'b0);
    cmp(tag, "release check_start", 32'(check_start), 32'(0));
    cyc(1'b1, 1'b1, c, 1'b0);
    expect_out(tag, sel, cs, tr, sc, rn);
  endtask

  initial begin
    rst = 1'b0; btn = 1'b1; check_result = CX; timer_finish = 1'b0;

    // Reset with button held, first round won, second lost on tries, third timed out.
    vecs.push_back(mk(0,1,CX,0, 3'd0,0,3'd5,4'd0,2'd0));
    vecs.push_back(mk(0,1,CX,1, 3'd0,0,3'd5,4'd0,2'd0));
    vecs.push_back(mk(1,1,CX,0, 3'd0,0,3'd5,4'd0,2'd0));
    vecs.push_back(mk(1,0,CX,0, 3'd0,0,3'd5,4'd0,2'd0));
    vecs.push_back(mk(1,1,CX,0, 3'd1,0,3'd5,4'd0,2'd0));
    vecs.push_back(mk(1,0,CW,0, 3'd1,0,3'd5,4'd0,2'd0));
    vecs.push_back(mk(1,1,CW,0, 3'd3,1,3'd5,4'd1,2'd0));
    vecs.push_back(mk(1,0,CX,1, 3'd3,0,3'd5,4'd1,2'd0));
    vecs.push_back(mk(1,1,CX,0, 3'd1,0,3'd5,4'd1,2'd1));
    vecs.push_back(mk(1,0,CX,0, 3'd1,0,3'd5,4'd1,2'd1));
    vecs.push_back(mk(1,1,CX,0, 3'd2,1,3'd4,4'd1,2'd1));
    vecs.push_back(mk(1,0,CX,0, 3'd2,0,3'd4,4'd1,2'd1));
    vecs.push_back(mk(1,1,CX,0, 3'd1,0,3'd4,4'd1,2'd1));
    vecs.push_back(mk(1,0,CX,0, 3'd1,0,3'd4,4'd1,2'd1));
    vecs.push_back(mk(1,1,CX,0, 3'd2,1,3'd3,4'd1,2'd1));
    vecs.push_back(mk(1,0,CX,0, 3'd2,0,3'd3,4'd1,2'd1));
    vecs.push_back(mk(1,1,CX,0, 3'd1,0,3'd3,4'd1,2'd1));
    vecs.push_back(mk(1,0,CX,0, 3'd1,0,3'd3,4'd1,2'd1));
    vecs.push_back(mk(1,1,CX,0, 3'd2,1,3'd2,4'd1,2'd1));
    vecs.push_back(mk(1,0,CX,0, 3'd2,0,3'd2,4'd1,2'd1));
    vecs.push_back(mk(1,1,CX,0, 3'd1,0,3'd2,4'd1,2'd1));
    vecs.push_back(mk(1,0,CX,0, 3'd1,0,3'd2,4'd1,2'd1));
    vecs.push_back(mk(1,1,CX,0, 3'd2,1,3'd1,4'd1,2'd1));
    vecs.push_back(mk(1,0,CX,0, 3'd2,0,3'd1,4'd1,2'd1));
    vecs.push_back(mk(1,1,CX,0, 3'd1,0,3'd1,4'd1,2'd1));
    vecs.push_back(mk(1,0,CX,0, 3'd1,0,3'd1,4'd1,2'd1));
    vecs.push_back(mk(1,1,CX,0, 3'd4,1,3'd0,4'd1,2'd1));
    vecs.push_back(mk(1,0,CX,1, 3'd4,0,3'd0,4'd1,2'd1));
    vecs.push_back(mk(1,1,CX,0, 3'd1,0,3'd5,4'd1,2'd2));
    vecs.push_back(mk(1,0,CW,0, 3'd1,0,3'd5,4'd1,2'd2));
    vecs.push_back(mk(1,1,CW,1, 3'd4,0,3'd5,4'd1,2'd2));
    vecs.push_back(mk(1,0,CX,0, 3'd4,0,3'd5,4'd1,2'd2));
    vecs.push_back(mk(1,1,CX,0, 3'd5,0,3'd5,4'd1,2'd2));
    vecs.push_back(mk(1,0,CX,1, 3'd5,0,3'd5,4'd1,2'd2));
    vecs.push_back(mk(1,1,CX,0, 3'd0,0,3'd5,4'd0,2'd0));

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].b, vecs[i].c, vecs[i].t);
      expect_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].cs,
                 vecs[i].tr, vecs[i].sc, vecs[i].rn);
    end

    // Win, lose by timeout in HINT, win: score 2, then OVER and back to IDLE.
    press("g_start", CX, 3'd1, 0, 3'd5, 4'd0, 2'd0);
    press("g_win0",  CW, 3'd3, 1, 3'd5, 4'd1, 2'd0);
    press("g_next1", CX, 3'd1, 0, 3'd5, 4'd1, 2'd1);
    press("g_miss1", CX, 3'd2, 1, 3'd4, 4'd1, 2'd1);
    cyc(1'b1, 1'b0, CX, 1'b1);
    expect_out("g_hint_to", 3'd4, 0, 3'd4, 4'd1, 2'd1);
    press("g_next2", CX, 3'd1, 0, 3'd5, 4'd1, 2'd2);
    press("g_win2",  CW, 3'd3, 1, 3'd5, 4'd2, 2'd2);
    press("g_over",  CX, 3'd5, 0, 3'd5, 4'd2, 2'd2);
    press("g_idle",  CX, 3'd0, 0, 3'd5, 4'd0, 2'd0);

    // Reset asserted in HINT together with a press and a timeout.
    press("r_start", CX, 3'd1, 0, 3'd5, 4'd0, 2'd0);
    press("r_win",   CW, 3'd3, 1, 3'd5, 4'd1, 2'd0);
    press("r_next",  CX, 3'd1, 0, 3'd5, 4'd1, 2'd1);
    press("r_miss1", CX, 3'd2, 1, 3'd4, 4'd1, 2'd1);
    press("r_back",  CX, 3'd1, 0, 3'd4, 4'd1, 2'd1);
    press("r_miss2", CX, 3'd2, 1, 3'd3, 4'd1, 2'd1);
    cyc(1'b1, 1'b0, CX, 1'b0);
    expect_out("r_hold", 3'd2, 0, 3'd3, 4'd1, 2'd1);
    cyc(1'b0, 1'b1, CW, 1'b1);
    expect_out("r_rst", 3'd0, 0, 3'd5, 4'd0, 2'd0);
    cyc(1'b1, 1'b1, CX, 1'b0);
    expect_out("r_held", 3'd0, 0, 3'd5, 4'd0, 2'd0);
    press("r_press", CX, 3'd1, 0, 3'd5, 4'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
